// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit holding the HI/LO registers.
// Results are computed at launch and committed when the busy window closes.
module ex_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   phi_q, plo_q;
  logic          pwr_q;

  logic op_mul, op_div, op_mthi, op_mtlo, sgn;
  logic [63:0] a64, b64, prod;
  logic a_neg, b_neg, dz;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] uq, ur, q, r;

  assign op_mul  = start && (op == 3'd1 || op == 3'd2);
  assign op_div  = start && (op == 3'd3 || op == 3'd4);
  assign op_mthi = start && (op == 3'd5);
  assign op_mtlo = start && (op == 3'd6);
  assign sgn     = (op == 3'd1) || (op == 3'd3);

  assign a64  = sgn ? {{32{rd1[31]}}, rd1} : {32'b0, rd1};
  assign b64  = sgn ? {{32{rd2[31]}}, rd2} : {32'b0, rd2};
  assign prod = a64 * b64;

  // Magnitude divide then re-sign; avoids signed overflow on INT_MIN/-1.
  assign a_neg  = sgn && rd1[31];
  assign b_neg  = sgn && rd2[31];
  assign a_mag  = a_neg ? -rd1 : rd1;
  assign b_mag  = b_neg ? -rd2 : rd2;
  assign dz     = (rd2 == 32'd0);
  assign b_safe = dz ? 32'd1 : b_mag;
  assign uq     = a_mag / b_safe;
  assign ur     = a_mag % b_safe;
  assign q      = (a_neg ^ b_neg) ? -uq : uq;
  assign r      = a_neg ? -ur : ur;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      pwr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          unique case (1'b1)
            op_mul: begin
              phi_q   <= prod[63:32];
              plo_q   <= prod[31:0];
              pwr_q   <= 1'b1;
              cnt_q   <= CW'(MULT_CYCLES);
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
            op_div: begin
              phi_q   <= r;
              plo_q   <= q;
              pwr_q   <= !dz;
              cnt_q   <= CW'(DIV_CYCLES);
              busy_q  <= 1'b1;
              state_q <= S_RUN;
            end
            op_mthi: hi_q <= rd1;
            op_mtlo: lo_q <= rd1;
            default: ;
          endcase
        end
        S_RUN: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            if (pwr_q) begin
              hi_q <= phi_q;
              lo_q <= plo_q;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: arithmetic model plus
// per-cycle compare of busy/hi/lo.
module tb_ex_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rd1, rd2;
  logic        busy;
  logic [31:0] hi, lo;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit cmp_en = 1'b0;

  ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rd1(rd1), .rd2(rd2), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Model: results from plain 64-bit arithmetic,
  // commit scheduled at an absolute cycle number.
  logic        m_busy;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_wr;
  longint      m_cyc, m_done;

  task automatic calc(input logic [2:0] o,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      output bit wr,
                      output logic [31:0] h,
                      output logic [31:0] l);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    wr = 1'b1; h = 0; l = 0;
    case (o)
      3'd1: begin p = 64'(sa * sb); h = p[63:32]; l = p[31:0]; end
      3'd2: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32]; l = p[31:0];
      end
      3'd3: begin
        if (b == 0) wr = 1'b0;
        else begin
          p = 64'(sa / sb); l = p[31:0];
          p = 64'(sa % sb); h = p[31:0];
        end
      end
      default: begin
        if (b == 0) wr = 1'b0;
        else begin l = a / b; h = a % b; end
      end
    endcase
  endtask

  initial begin
    m_busy = 0; m_hi = 0; m_lo = 0; m_cyc = 0; m_done = 0;
    m_phi = 0; m_plo = 0; m_wr = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_busy = 0; m_hi = 0; m_lo = 0;
      end else if (clk) begin
        m_cyc++;
        if (m_busy) begin
          if (m_cyc == m_done) begin
            m_busy = 0;
            if (m_wr) begin m_hi = m_phi; m_lo = m_plo; end
          end
        end else if (start) begin
          if (op >= 3'd1 && op <= 3'd4) begin
            calc(op, rd1, rd2, m_wr, m_phi, m_plo);
            m_busy = 1;
            m_done = m_cyc + ((op <= 3'd2) ? MC : DC);
          end else if (op == 3'd5) m_hi = rd1;
          else if (op == 3'd6) m_lo = rd1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
        chk("cyc_hi", hi, m_hi);
        chk("cyc_lo", lo, m_lo);
      end
    end
  end

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; rd1 = a; rd2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
  endtask

  task automatic run_count(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    if (busy) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  int n;

  initial begin
    reset = 1'b0; start = 1'b0; op = 3'd0; rd1 = 0; rd2 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b1;
    cmp_en = 1'b1;

    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi_hold", hi, 32'd0);
    run_count(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    issue(3'd2, 32'hFFFFFFFF, 32'd2);
    run_count(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    issue(3'd4, 32'd7, 32'd2);
    run_count(n);
    chk("divu_cycles", 32'(n), 32'd10);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    run_count(n);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'hFFFFFFFF);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    run_count(n);
    chk("div_ovf_lo", lo, 32'h80000000);
    chk("div_ovf_hi", hi, 32'd0);

    issue(3'd5, 32'h11, 32'd0);
    chk("mthi_hi", hi, 32'h11);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    chk("mtlo_lo", lo, 32'h22);
    issue(3'd3, 32'd5, 32'd0);
    run_count(n);
    chk("dz_cycles", 32'(n), 32'd10);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    issue(3'd5, 32'hDEADBEEF, 32'd0);
    chk("mthi2_hi", hi, 32'hDEADBEEF);
    chk("mthi2_busy", {31'b0, busy}, 32'd0);

    issue(3'd1, 32'd3, 32'd4);
    rd1 = 32'd99; rd2 = 32'd77;
    @(negedge clk);
    start = 1'b1; op = 3'd6; rd1 = 32'h5555;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    for (int i = 0; i < 2; i++) begin
      rd1 = $urandom; rd2 = $urandom;
      @(negedge clk);
    end
    run_count(n);
    chk("iso_lo", lo, 32'd12);
    chk("iso_hi", hi, 32'd0);

    issue(3'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_busy", {31'b0, busy}, 32'd0);
    chk("post_hi", hi, 32'd0);
    chk("post_lo", lo, 32'd0);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
